// File: rtl/sched_pkg.sv
// Shared types, error codes and field helper for the layer schedule controller.
package sched_pkg;

  // Run sequencer states.
  typedef enum logic [3:0] {
    IDLE,
    RD_ST,
    RD_WT,
    GRP_CHK,
    CV_ST,
    CV_WT,
    PL_ST,
    PL_WT,
    WR_ST,
    WR_WT,
    DONE
  } sched_state_t;

  // err_code encodings.
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_UART_TO = 2'd1;
  localparam logic [1:0] ERR_CONV_TO = 2'd2;
  localparam logic [1:0] ERR_POOL_TO = 2'd3;

  // Widest packed per-group vector and widest single field the helper handles.
  localparam int VEC_MAX_W   = 64;
  localparam int FIELD_MAX_W = 16;

  // Extract field idx of width w from a packed per-group vector. Indices past
  // the populated part of the vector read as zero, so an index equal to the
  // group count is harmless.
  function automatic logic [FIELD_MAX_W-1:0] grp_field(
    input logic [VEC_MAX_W-1:0] vec,
    input int unsigned          idx,
    input int unsigned          w
  );
    logic [VEC_MAX_W-1:0] shifted;
    logic [VEC_MAX_W-1:0] mask;
    shifted = vec >> (idx * w);
    mask    = (VEC_MAX_W'(1) << w) - VEC_MAX_W'(1);
    shifted = shifted & mask;
    return shifted[FIELD_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/sched_wdog.sv
// Wait-state watchdog: counts cycles while enabled, flags the cycle on which
// the count steps onto all-ones.
module sched_wdog
  import sched_pkg::*;
#(
  parameter int WDOG_W = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  // Count value from which the next increment lands on all-ones.
  localparam logic [WDOG_W-1:0] LAST_BEFORE_FULL = ~WDOG_W'(1);

  logic [WDOG_W-1:0] cnt_reg;

  // Cycle counter; cleared whenever the controller is outside a wait state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + WDOG_W'(1);
    end
  end

  // Depends only on the register so the controller can use it combinationally.
  assign expire = (cnt_reg == LAST_BEFORE_FULL);

endmodule

// File: rtl/layer_sched_ctrl.sv
// Top-level run sequencer: UART input load, programmable conv/pool group
// schedule with filter address generation, UART write-back, watchdog and abort.
module layer_sched_ctrl
  import sched_pkg::*;
#(
  parameter int MAX_GROUPS = 4,
  parameter int CNT_W      = 4,
  parameter int ADDR_W     = 28,
  parameter int WDOG_W     = 20,
  parameter int GRP_W      = $clog2(MAX_GROUPS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [GRP_W-1:0]            cfg_groups,
  input  logic [MAX_GROUPS*CNT_W-1:0] cfg_conv_cnt,
  input  logic [MAX_GROUPS-1:0]       cfg_pool_en,
  input  logic [ADDR_W-1:0]           cfg_flt_base,
  input  logic [ADDR_W-1:0]           cfg_flt_stride,
  output logic                        uart_start,
  output logic                        uart_wr_sel,
  input  logic                        uart_done,
  output logic                        conv_start,
  output logic [ADDR_W-1:0]           conv_flt_addr,
  input  logic                        conv_done,
  output logic                        pool_start,
  input  logic                        pool_done,
  output logic                        busy,
  output logic                        sys_done,
  output logic                        err,
  output logic [1:0]                  err_code
);

  localparam logic [GRP_W-1:0] MAX_GRP = GRP_W'(MAX_GROUPS);

  sched_state_t state_reg, state_next;

  // Run configuration captured at start.
  logic [GRP_W-1:0]            groups_reg, groups_next;
  logic [MAX_GROUPS*CNT_W-1:0] conv_cnt_reg, conv_cnt_next;
  logic [MAX_GROUPS-1:0]       pool_en_reg, pool_en_next;
  logic [ADDR_W-1:0]           stride_reg, stride_next;

  // Progress counters and address accumulator.
  logic [GRP_W-1:0]            grp_idx_reg, grp_idx_next;
  logic [CNT_W-1:0]            conv_idx_reg, conv_idx_next;
  logic [ADDR_W-1:0]           addr_reg, addr_next;

  logic                        err_reg, err_next;
  logic [1:0]                  err_code_reg, err_code_next;

  logic                        wdog_en;
  logic                        wdog_expire;

  logic [GRP_W-1:0]            groups_clamped;
  logic [CNT_W-1:0]            cur_conv_cnt;
  logic                        cur_pool_en;
  logic                        more_convs;

  assign groups_clamped = (cfg_groups > MAX_GRP) ? MAX_GRP : cfg_groups;

  assign cur_conv_cnt = CNT_W'(grp_field(VEC_MAX_W'(conv_cnt_reg), 32'(grp_idx_reg), CNT_W));
  assign cur_pool_en  = 1'(grp_field(VEC_MAX_W'(pool_en_reg), 32'(grp_idx_reg), 1));

  // Another conv remains in this group after the one just completed.
  assign more_convs = ((CNT_W+1)'(conv_idx_reg) + (CNT_W+1)'(1)) < (CNT_W+1)'(cur_conv_cnt);

  sched_wdog #(
    .WDOG_W (WDOG_W)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (~wdog_en),
    .en     (wdog_en),
    .expire (wdog_expire)
  );

  // State, configuration, counters and error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      groups_reg   <= '0;
      conv_cnt_reg <= '0;
      pool_en_reg  <= '0;
      stride_reg   <= '0;
      grp_idx_reg  <= '0;
      conv_idx_reg <= '0;
      addr_reg     <= '0;
      err_reg      <= 1'b0;
      err_code_reg <= ERR_NONE;
    end else begin
      state_reg    <= state_next;
      groups_reg   <= groups_next;
      conv_cnt_reg <= conv_cnt_next;
      pool_en_reg  <= pool_en_next;
      stride_reg   <= stride_next;
      grp_idx_reg  <= grp_idx_next;
      conv_idx_reg <= conv_idx_next;
      addr_reg     <= addr_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
    end
  end

  // Next-state, datapath updates and Moore outputs; abort overrides everything.
  always_comb begin
    state_next    = state_reg;
    groups_next   = groups_reg;
    conv_cnt_next = conv_cnt_reg;
    pool_en_next  = pool_en_reg;
    stride_next   = stride_reg;
    grp_idx_next  = grp_idx_reg;
    conv_idx_next = conv_idx_reg;
    addr_next     = addr_reg;
    err_next      = err_reg;
    err_code_next = err_code_reg;
    uart_start    = 1'b0;
    uart_wr_sel   = 1'b1;
    conv_start    = 1'b0;
    pool_start    = 1'b0;
    sys_done      = 1'b0;
    wdog_en       = 1'b0;

    if (abort) begin
      state_next    = IDLE;
      grp_idx_next  = '0;
      conv_idx_next = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            groups_next   = groups_clamped;
            conv_cnt_next = cfg_conv_cnt;
            pool_en_next  = cfg_pool_en;
            stride_next   = cfg_flt_stride;
            addr_next     = cfg_flt_base;
            grp_idx_next  = '0;
            conv_idx_next = '0;
            err_next      = 1'b0;
            err_code_next = ERR_NONE;
            state_next    = RD_ST;
          end
        end
        RD_ST: begin
          uart_start = 1'b1;
          state_next = RD_WT;
        end
        RD_WT: begin
          wdog_en = 1'b1;
          if (uart_done) begin
            state_next = GRP_CHK;
          end else if (wdog_expire) begin
            err_next      = 1'b1;
            err_code_next = ERR_UART_TO;
            state_next    = IDLE;
          end
        end
        GRP_CHK: begin
          if (grp_idx_reg == groups_reg) begin
            state_next = WR_ST;
          end else if (cur_conv_cnt != '0) begin
            state_next = CV_ST;
          end else if (cur_pool_en) begin
            state_next = PL_ST;
          end else begin
            grp_idx_next = grp_idx_reg + GRP_W'(1);
          end
        end
        CV_ST: begin
          conv_start = 1'b1;
          state_next = CV_WT;
        end
        CV_WT: begin
          wdog_en = 1'b1;
          if (conv_done) begin
            addr_next = addr_reg + stride_reg;
            if (more_convs) begin
              conv_idx_next = conv_idx_reg + CNT_W'(1);
              state_next    = CV_ST;
            end else begin
              conv_idx_next = '0;
              if (cur_pool_en) begin
                state_next = PL_ST;
              end else begin
                grp_idx_next = grp_idx_reg + GRP_W'(1);
                state_next   = GRP_CHK;
              end
            end
          end else if (wdog_expire) begin
            err_next      = 1'b1;
            err_code_next = ERR_CONV_TO;
            state_next    = IDLE;
          end
        end
        PL_ST: begin
          pool_start = 1'b1;
          state_next = PL_WT;
        end
        PL_WT: begin
          wdog_en = 1'b1;
          if (pool_done) begin
            grp_idx_next = grp_idx_reg + GRP_W'(1);
            state_next   = GRP_CHK;
          end else if (wdog_expire) begin
            err_next      = 1'b1;
            err_code_next = ERR_POOL_TO;
            state_next    = IDLE;
          end
        end
        WR_ST: begin
          uart_start  = 1'b1;
          uart_wr_sel = 1'b0;
          state_next  = WR_WT;
        end
        WR_WT: begin
          uart_wr_sel = 1'b0;
          wdog_en     = 1'b1;
          if (uart_done) begin
            state_next = DONE;
          end else if (wdog_expire) begin
            err_next      = 1'b1;
            err_code_next = ERR_UART_TO;
            state_next    = IDLE;
          end
        end
        DONE: begin
          sys_done   = 1'b1;
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign busy          = (state_reg != IDLE);
  assign conv_flt_addr = addr_reg;
  assign err           = err_reg;
  assign err_code      = err_code_reg;

endmodule

// File: tb/tb_layer_sched_ctrl.sv
// Directed self-checking bench for layer_sched_ctrl.
module tb_layer_sched_ctrl;

  localparam int MAX_GROUPS = 4;
  localparam int CNT_W      = 4;
  localparam int ADDR_W     = 28;
  localparam int WDOG_W     = 4;
  localparam int GRP_W      = 3;

  // Event kinds recorded by the monitor.
  localparam int EV_RD   = 1;
  localparam int EV_WR   = 2;
  localparam int EV_CONV = 3;
  localparam int EV_POOL = 4;
  localparam int EV_DONE = 5;

  logic                        clk;
  logic                        rst_n;
  logic                        start;
  logic                        abort;
  logic [GRP_W-1:0]            cfg_groups;
  logic [MAX_GROUPS*CNT_W-1:0] cfg_conv_cnt;
  logic [MAX_GROUPS-1:0]       cfg_pool_en;
  logic [ADDR_W-1:0]           cfg_flt_base;
  logic [ADDR_W-1:0]           cfg_flt_stride;
  logic                        uart_start;
  logic                        uart_wr_sel;
  logic                        uart_done;
  logic                        conv_start;
  logic [ADDR_W-1:0]           conv_flt_addr;
  logic                        conv_done;
  logic                        pool_start;
  logic                        pool_done;
  logic                        busy;
  logic                        sys_done;
  logic                        err;
  logic [1:0]                  err_code;

  // Responder state.
  logic uart_done_r, conv_done_r, pool_done_r;
  logic inj_conv, inj_pool;
  int   u_cnt, c_cnt, p_cnt;
  int   u_dly, c_dly, p_dly;
  bit   c_en;

  int   ev_kind[$];
  int   ev_addr[$];
  int   exp_kind[$];
  int   exp_addr[$];

  int   n_checks;
  int   n_errors;
  int   n;

  assign uart_done = uart_done_r;
  assign conv_done = conv_done_r | inj_conv;
  assign pool_done = pool_done_r | inj_pool;

  layer_sched_ctrl #(
    .MAX_GROUPS (MAX_GROUPS),
    .CNT_W      (CNT_W),
    .ADDR_W     (ADDR_W),
    .WDOG_W     (WDOG_W),
    .GRP_W      (GRP_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .cfg_groups     (cfg_groups),
    .cfg_conv_cnt   (cfg_conv_cnt),
    .cfg_pool_en    (cfg_pool_en),
    .cfg_flt_base   (cfg_flt_base),
    .cfg_flt_stride (cfg_flt_stride),
    .uart_start     (uart_start),
    .uart_wr_sel    (uart_wr_sel),
    .uart_done      (uart_done),
    .conv_start     (conv_start),
    .conv_flt_addr  (conv_flt_addr),
    .conv_done      (conv_done),
    .pool_start     (pool_start),
    .pool_done      (pool_done),
    .busy           (busy),
    .sys_done       (sys_done),
    .err            (err),
    .err_code       (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine models: a done pulse arrives the programmed number of cycles after
  // the start pulse (1 = the cycle right after the start cycle).
  always @(negedge clk) begin
    if (uart_start) u_cnt <= u_dly;
    else if (u_cnt > 0) u_cnt <= u_cnt - 1;
    uart_done_r <= (u_cnt == 1);
    if (conv_start) c_cnt <= c_dly;
    else if (c_cnt > 0) c_cnt <= c_cnt - 1;
    conv_done_r <= (c_cnt == 1) && c_en;
    if (pool_start) p_cnt <= p_dly;
    else if (p_cnt > 0) p_cnt <= p_cnt - 1;
    pool_done_r <= (p_cnt == 1);
  end

  // Transaction monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (uart_start) begin
        ev_kind.push_back(uart_wr_sel ? EV_RD : EV_WR);
        ev_addr.push_back(0);
        $display("[%0t] uart_start wr_sel=%0d", $time, uart_wr_sel);
      end
      if (conv_start) begin
        ev_kind.push_back(EV_CONV);
        ev_addr.push_back(int'(conv_flt_addr));
        $display("[%0t] conv_start addr=0x%0h", $time, conv_flt_addr);
      end
      if (pool_start) begin
        ev_kind.push_back(EV_POOL);
        ev_addr.push_back(0);
        $display("[%0t] pool_start", $time);
      end
      if (sys_done) begin
        ev_kind.push_back(EV_DONE);
        ev_addr.push_back(0);
        $display("[%0t] sys_done", $time);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input int k, input int a);
    exp_kind.push_back(k);
    exp_addr.push_back(a);
  endtask

  task automatic clear_logs();
    ev_kind.delete();
    ev_addr.delete();
    exp_kind.delete();
    exp_addr.delete();
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, 32'(ev_kind.size()), 32'(exp_kind.size()));
    for (int i = 0; i < exp_kind.size() && i < ev_kind.size(); i++) begin
      check($sformatf("%s_kind%0d", tag, i), 32'(ev_kind[i]), 32'(exp_kind[i]));
      check($sformatf("%s_addr%0d", tag, i), 32'(ev_addr[i]), 32'(exp_addr[i]));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_sys(input string tag, input int budget);
    int k;
    k = 0;
    while (sys_done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(sys_done), 32'd1);
    tick();
    tick();
  endtask

  task automatic wait_conv(input string tag, input int budget);
    int k;
    k = 0;
    while (conv_start !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(conv_start), 32'd1);
  endtask

  task automatic cfg_basic();
    cfg_groups     = 3'd2;
    cfg_conv_cnt   = {4'd0, 4'd0, 4'd1, 4'd2};
    cfg_pool_en    = 4'b0011;
    cfg_flt_base   = 28'h100;
    cfg_flt_stride = 28'h40;
  endtask

  task automatic exp_basic();
    exp_push(EV_RD, 0);
    exp_push(EV_CONV, 'h100);
    exp_push(EV_CONV, 'h140);
    exp_push(EV_POOL, 0);
    exp_push(EV_CONV, 'h180);
    exp_push(EV_POOL, 0);
    exp_push(EV_WR, 0);
    exp_push(EV_DONE, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    inj_conv = 1'b0;
    inj_pool = 1'b0;
    u_dly = 3; c_dly = 3; p_dly = 3;
    c_en = 1'b1;
    cfg_basic();
    repeat (3) @(posedge clk);
    #1;

    // Reset state.
    check("rst_uart_wr_sel", 32'(uart_wr_sel), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_uart_start", 32'(uart_start), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_addr", 32'(conv_flt_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic run.
    clear_logs();
    exp_basic();
    pulse_start();
    check("basic_busy", 32'(busy), 32'd1);
    wait_sys("basic_sys_done", 200);
    check_log("basic");
    check("basic_idle", 32'(busy), 32'd0);

    // Empty-group skipping.
    clear_logs();
    cfg_groups     = 3'd3;
    cfg_conv_cnt   = {4'd0, 4'd0, 4'd0, 4'd1};
    cfg_pool_en    = 4'b0100;
    cfg_flt_base   = 28'h200;
    cfg_flt_stride = 28'h10;
    exp_push(EV_RD, 0);
    exp_push(EV_CONV, 'h200);
    exp_push(EV_POOL, 0);
    exp_push(EV_WR, 0);
    exp_push(EV_DONE, 0);
    pulse_start();
    wait_sys("skip_sys_done", 200);
    check_log("skip");

    // Zero groups, fastest responders: sys_done in the 7th cycle counting the
    // start cycle as the 1st, i.e. 5 edges after the edge that samples start.
    clear_logs();
    u_dly = 1; c_dly = 1; p_dly = 1;
    cfg_groups = 3'd0;
    exp_push(EV_RD, 0);
    exp_push(EV_WR, 0);
    exp_push(EV_DONE, 0);
    pulse_start();
    n = 0;
    while (sys_done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("zero_latency", 32'(n), 32'd5);
    tick();
    check("zero_wr_sel_back", 32'(uart_wr_sel), 32'd1);
    check("zero_idle", 32'(busy), 32'd0);
    tick();
    check_log("zero");

    // Conv timeout: 15 cycles in CV_WT, then IDLE with err_code=2.
    clear_logs();
    cfg_groups   = 3'd1;
    cfg_conv_cnt = {4'd0, 4'd0, 4'd0, 4'd1};
    cfg_pool_en  = 4'b0000;
    c_en = 1'b0;
    pulse_start();
    wait_conv("to_conv_start", 50);
    n = 0;
    while (err !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check("to_edges_to_err", 32'(n), 32'd16);
    check("to_err_code", 32'(err_code), 32'd2);
    check("to_busy", 32'(busy), 32'd0);
    tick();
    check("to_err_sticky", 32'(err), 32'd1);
    exp_push(EV_RD, 0);
    exp_push(EV_CONV, 'h200);
    check_log("to");
    c_en = 1'b1;
    clear_logs();
    pulse_start();
    check("to_clear_err", 32'(err), 32'd0);
    check("to_clear_code", 32'(err_code), 32'd0);
    wait_sys("to_rerun_done", 200);

    // Abort together with start: run not started.
    clear_logs();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abst_busy", 32'(busy), 32'd0);
    tick();
    check("abst_no_events", 32'(ev_kind.size()), 32'd0);

    // Abort mid CV_WT, late conv_done ignored, then a normal basic run.
    clear_logs();
    cfg_basic();
    u_dly = 3; c_dly = 8; p_dly = 3;
    pulse_start();
    wait_conv("ab_conv_start", 50);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_idle", 32'(busy), 32'd0);
    check("ab_no_sys_done", 32'(sys_done), 32'd0);
    repeat (12) tick();
    check("ab_still_idle", 32'(busy), 32'd0);
    check("ab_err", 32'(err), 32'd0);
    exp_push(EV_RD, 0);
    exp_push(EV_CONV, 'h100);
    check_log("ab");
    clear_logs();
    c_dly = 3;
    exp_basic();
    pulse_start();
    wait_sys("ab_rerun_done", 200);
    check_log("ab_rerun");

    // Address wrap and a stray pool_done during CV_WT.
    clear_logs();
    cfg_groups     = 3'd1;
    cfg_conv_cnt   = {4'd0, 4'd0, 4'd0, 4'd2};
    cfg_pool_en    = 4'b0000;
    cfg_flt_base   = 28'hFFFFFF0;
    cfg_flt_stride = 28'h20;
    c_dly = 5;
    exp_push(EV_RD, 0);
    exp_push(EV_CONV, 'hFFFFFF0);
    exp_push(EV_CONV, 'h10);
    exp_push(EV_WR, 0);
    exp_push(EV_DONE, 0);
    pulse_start();
    wait_conv("wrap_conv_start", 50);
    tick();
    inj_pool = 1'b1;
    tick();
    inj_pool = 1'b0;
    check("wrap_stray_busy", 32'(busy), 32'd1);
    check("wrap_stray_err", 32'(err), 32'd0);
    wait_sys("wrap_sys_done", 200);
    check_log("wrap");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
